// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: controller state encoding and default operand width.
package serial_add_pkg;

   localparam int SA_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fa_bit_cell.sv
// Combinational 1-bit full adder; zero latency, no flow control.
module fa_bit_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB-first, result valid WIDTH cycles after accept.
// Result held in DONE until out_ready; in_ready only in IDLE. SERIAL_ADD_SUB_EN adds sub/res_sub (a-b).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
   output logic             res_sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_shift;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             cout_q;
   logic             cell_s;
   logic             cell_cout;

   fa_bit_cell u_cell (
      .a    (op_a[0]),
      .b    (op_b[0]),
      .cin  (carry),
      .s    (cell_s),
      .cout (cell_cout)
   );

   // New sum bit enters at the MSB so the LSB-first result lands in place after WIDTH shifts.
   generate
      if (WIDTH == 1) begin : g_shift_w1
         always_comb sum_shift = cell_s;
      end else begin : g_shift_wn
         always_comb sum_shift = {cell_s, sum_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == LAST_BIT) state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         sum_q  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         res_sub <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_a  <= a;
                  sum_q <= '0;
                  cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                  // Subtract as a + ~b + 1; cin is ignored in that mode.
                  res_sub <= sub;
                  if (sub) begin
                     op_b  <= ~b;
                     carry <= 1'b1;
                  end else begin
                     op_b  <= b;
                     carry <= cin;
                  end
`else
                  op_b  <= b;
                  carry <= cin;
`endif
               end
            end
            RUN: begin
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               sum_q <= sum_shift;
               carry <= cell_cout;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) cout_q <= cell_cout;
            end
            default: ;
         endcase
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus a scoreboarded random regression.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub;
   logic         res_sub;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [W:0] sb[$];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub       (sub),
      .res_sub   (res_sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Called at a negedge while IDLE; returns at the negedge after the accept edge.
   task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tc, input logic tsub);
      logic [W:0] expv;
      a        = ta;
      b        = tb_v;
      cin      = tc;
`ifdef SERIAL_ADD_SUB_EN
      sub      = tsub;
`endif
      in_valid = 1'b1;
      if (tsub) expv = {1'b0, ta} + {1'b0, ~tb_v} + (W+1)'(1);
      else      expv = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
      sb.push_back(expv);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts edges until out_valid is seen at a negedge, bounded.
   task automatic wait_out(output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_checks++; if ({cout, sum} !== 9'h000) begin n_fail++; $display("FAIL reset_result got=%h exp=000", {cout, sum}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_add();
      int cyc; bit ok; logic [W:0] expv;
      accept_op(8'h3C, 8'h15, 1'b0, 1'b0);
      n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
      wait_out(cyc, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_timeout got no out_valid exp out_valid within 40"); end
      n_checks++; if (cyc != W) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", cyc, W); end
      expv = sb.pop_front();
      n_checks++; if ({cout, sum} !== expv || expv !== 9'h051) begin n_fail++; $display("FAIL basic_result got=%h exp=051", {cout, sum}); end
      release_out();
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_return_idle got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
   endtask

   task automatic test_carry_ripple();
      int cyc; bit ok; logic [W:0] expv;
      logic [W-1:0] va[2]; logic [W-1:0] vb[2]; logic vc[2]; logic [W:0] vr[2];
      va[0] = 8'hFF; vb[0] = 8'h01; vc[0] = 1'b0; vr[0] = 9'h100;
      va[1] = 8'hFF; vb[1] = 8'hFF; vc[1] = 1'b1; vr[1] = 9'h1FF;
      for (int i = 0; i < 2; i++) begin
         accept_op(va[i], vb[i], vc[i], 1'b0);
         wait_out(cyc, ok);
         expv = sb.pop_front();
         n_checks++; if (!ok || {cout, sum} !== vr[i] || expv !== vr[i]) begin n_fail++; $display("FAIL carry_%0d got=%h exp=%h", i, {cout, sum}, vr[i]); end
         release_out();
      end
   endtask

   task automatic test_backpressure();
      int cyc; bit ok; logic [W:0] expv;
      accept_op(8'h12, 8'h34, 1'b1, 1'b0);
      wait_out(cyc, ok);
      expv = sb.pop_front();
      n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got no out_valid exp out_valid"); end
      for (int i = 0; i < 5; i++) begin
         a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
         n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== 9'h047)
            begin n_fail++; $display("FAIL bp_hold_%0d got ov=%b ir=%b res=%h exp ov=1 ir=0 res=047", i, out_valid, in_ready, {cout, sum}); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      n_checks++; if ({cout, sum} !== expv) begin n_fail++; $display("FAIL bp_result got=%h exp=%h", {cout, sum}, expv); end
      release_out();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
      n_checks++; if ({cout, sum} !== 9'h047) begin n_fail++; $display("FAIL bp_keep_result got=%h exp=047", {cout, sum}); end
      accept_op(8'h10, 8'h20, 1'b0, 1'b0);
      wait_out(cyc, ok);
      expv = sb.pop_front();
      n_checks++; if (!ok || {cout, sum} !== 9'h030 || expv !== 9'h030) begin n_fail++; $display("FAIL bp_followup got=%h exp=030", {cout, sum}); end
      release_out();
   endtask

   task automatic test_reset_mid_run();
      int cyc; bit ok; bit seen; logic [W:0] expv;
      accept_op(8'hAA, 8'h55, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
      n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
         begin n_fail++; $display("FAIL midrst_state got ir=%b busy=%b ov=%b exp 1/0/0", in_ready, busy, out_valid); end
      n_checks++; if ({cout, sum} !== 9'h000) begin n_fail++; $display("FAIL midrst_result got=%h exp=000", {cout, sum}); end
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_output got out_valid=1 exp no out_valid"); end
      accept_op(8'h01, 8'h02, 1'b0, 1'b0);
      wait_out(cyc, ok);
      expv = sb.pop_front();
      n_checks++; if (!ok || {cout, sum} !== 9'h003 || expv !== 9'h003) begin n_fail++; $display("FAIL midrst_new_op got=%h exp=003", {cout, sum}); end
      release_out();
   endtask

   task automatic test_random();
      int cyc; bit ok; int stall; logic [W:0] expv;
      for (int i = 0; i < 1000; i++) begin
         accept_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
         wait_out(cyc, ok);
         if (sb.size() == 0) begin
            n_checks++; n_fail++; $display("FAIL rand_sb_empty got output exp none");
            break;
         end
         expv = sb.pop_front();
         if (!ok) begin
            n_checks++; n_fail++; $display("FAIL rand_timeout_%0d got no out_valid exp out_valid", i);
            break;
         end
         stall = $urandom_range(0, 3);
         repeat (stall) @(negedge clk);
         n_checks++; if ({cout, sum} !== expv || out_valid !== 1'b1 || cyc != W)
            begin n_fail++; $display("FAIL rand_%0d got=%h ov=%b lat=%0d exp=%h ov=1 lat=%0d", i, {cout, sum}, out_valid, cyc, expv, W); end
         release_out();
      end
   endtask

`ifdef SERIAL_ADD_SUB_EN
   task automatic test_sub();
      int cyc; bit ok; logic [W:0] expv;
      accept_op(8'h05, 8'h07, 1'b0, 1'b1);
      wait_out(cyc, ok);
      expv = sb.pop_front();
      n_checks++; if (!ok || {cout, sum} !== 9'h0FE || expv !== 9'h0FE || res_sub !== 1'b1)
         begin n_fail++; $display("FAIL sub_borrow got=%h tag=%b exp=0FE tag=1", {cout, sum}, res_sub); end
      release_out();
      accept_op(8'h07, 8'h05, 1'b1, 1'b1);
      wait_out(cyc, ok);
      expv = sb.pop_front();
      n_checks++; if (!ok || {cout, sum} !== 9'h102 || expv !== 9'h102)
         begin n_fail++; $display("FAIL sub_no_borrow got=%h exp=102", {cout, sum}); end
      release_out();
      sub = 1'b0;
   endtask
`endif

   initial begin
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      sub       = 1'b0;
`endif
      rst_n     = 1'b0;
      @(negedge clk);
      test_reset();
      test_basic_add();
      test_carry_ripple();
      test_backpressure();
      test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
      test_sub();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder controller. It sequences a single 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands LSB-first, holding the running carry in a flop. It has a valid/ready handshake on input and output, so it can sit between any operand producer and result consumer in place of a WIDTH-bit ripple adder when area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..64.
- CNT_W, $clog2(WIDTH)+1, bit-position counter width; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, operands a/b/cin valid.
- in_ready, output, 1, block can accept operands (IDLE only).
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, result sum.
- cout, output, 1, final carry-out.
- busy, output, 1, high in RUN or DONE.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n sampled on the clk rising edge).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, internal carry=0, counter=0.
- States:
  - IDLE: in_ready=1.
  - RUN: one bit per cycle.
  - DONE: out_valid=1.
- Accept, IDLE->RUN: on in_valid&&in_ready at edge k:
  - load shift regs opA<=a, opB<=b;
  - carry<=cin; cnt<=0; sum register cleared.
- RUN, each cycle:
  - cell inputs: opA[0], opB[0], carry;
  - sum<={s, sum[WIDTH-1:1]} (right shift, MSB entry);
  - carry<=cell cout; opA/opB shift right; cnt<=cnt+1.
- RUN->DONE: on the edge where cnt==WIDTH-1. At that edge, cout<=cell cout.
- Latency: out_valid is high after edge k+WIDTH, i.e. WIDTH cycles after accept.
- DONE: sum and cout are held stable while out_valid=1. On out_valid&&out_ready, go to IDLE; sum and cout keep their last value until the next accept.
- Back-to-back: no same-cycle DONE->accept. in_ready rises the cycle after the output transfer. Throughput is one result per WIDTH+2 cycles at most.
- in_valid while busy: ignored, in_ready=0. The producer must hold its operands until in_ready.
- out_ready while not DONE: no effect.
- Reset mid-operation: rst_n=0 at any state returns all registers to reset values on that edge. The partial result is discarded and no out_valid is produced.
- WIDTH=1: a single RUN cycle, then DONE.
- Arithmetic: result is exactly {cout,sum} = a+b+cin modulo 2^(WIDTH+1).

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined:
  - adds input port sub (1 bit), sampled at accept;
  - sub=1 loads opB<=~b and carry<=1, ignoring cin, so sum=a-b;
  - cout=1 means no borrow; a sub flag is registered so the result is tagged.
- Undefined: no sub port; add-only as above.

Decomposition:
- Package serial_add_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - default width constant SA_WIDTH_DEF=8.
- Sub-module fa_bit_cell is a combinational 1-bit full adder (a,b,cin -> s,cout), instantiated once.
- The controller holds all state, shift registers and counter.

Test Plan:
- Basic add (WIDTH=8): a=0x3C, b=0x15, cin=0 -> sum=0x51, cout=0, out_valid exactly 8 cycles after the accept edge.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout stable. in_valid pulses with new operands are ignored (in_ready=0). The transfer completes on the first out_ready=1, then in_ready=1 the next cycle.
- Reset mid-RUN: accept a=0xAA, b=0x55, drop rst_n for 1 cycle at bit 4 -> IDLE, sum=0, cout=0, no out_valid. A new operation a=0x01, b=0x02 -> sum=0x03.
- Random regression: 1000 random a, b, cin with random out_ready stalls -> {cout,sum}==a+b+cin every time.
- SERIAL_ADD_SUB_EN: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0. Then sub=1, a=0x07, b=0x05 -> sum=0x02, cout=1.
